// File: rtl/clock_pkg.sv
// clock_pkg: FSM state encoding, BCD limits and BCD increment helper for tick_time_counter
package clock_pkg;
   localparam logic [1:0] ST_STOPPED = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_SETTING = 2'd2;
   typedef enum logic [1:0] {
      STOPPED = ST_STOPPED,
      RUNNING = ST_RUNNING,
      SETTING = ST_SETTING
   } state_t;
   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping MAX_BCD -> 00 with a carry pulse on wrap
module bcd_mod_counter import clock_pkg::*; #(
   parameter logic [7:0] MAX_BCD = 8'h59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] value,
   output logic       carry
);
   assign carry = inc & ~clr & (value == MAX_BCD);
   // clear wins over increment; a wrapping increment lands on 00
   always_ff @(posedge clk)
      value <= (rst | clr | carry) ? 8'h00 : inc ? bcd_inc(value) : value;
endmodule

// File: rtl/tick_time_counter.sv
// tick_time_counter: 24 h HH:MM:SS BCD clock with run/stop, clear and set mode; ALARM_EN adds the alarm pulse
module tick_time_counter import clock_pkg::*; #(
   parameter int TICK_DIV      = 1,
   parameter bit START_RUNNING = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       run,
   input  logic       clear,
   input  logic       set_en,
   input  logic       inc_hour,
   input  logic       inc_min,
   input  logic [7:0] alarm_hour,
   input  logic [7:0] alarm_min,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic       running,
   output logic       day_wrap,
   output logic       alarm
);
   state_t     state, state_n;
   logic [7:0] div;
   logic       last_div, cnt_tick, sec_inc, sec_carry, min_carry, hour_carry;
   assign last_div = div == 8'(TICK_DIV - 1);
   assign cnt_tick = (state == RUNNING) & tick;
   assign sec_inc  = cnt_tick & last_div;
   // state register
   always_ff @(posedge clk)
      state <= rst ? (START_RUNNING ? RUNNING : STOPPED) : state_n;
   // mode selection: set_en dominates, otherwise run chooses RUNNING or STOPPED
   always_comb begin
      state_n = STOPPED;
      running = 1'b0;
      state_n = set_en ? SETTING : run ? RUNNING : STOPPED;
      running = state == RUNNING;
   end
   // tick prescaler; cleared on clear and while setting so counting resumes after a full period
   always_ff @(posedge clk)
      div <= (rst | clear | set_en) ? 8'h00 : cnt_tick ? (last_div ? 8'h00 : div + 8'h01) : div;
   bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
      .clk(clk), .rst(rst), .clr(clear | set_en), .inc(sec_inc),
      .value(sec_bcd), .carry(sec_carry)
   );
   bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
      .clk(clk), .rst(rst), .clr(clear), .inc(set_en ? inc_min : sec_carry),
      .value(min_bcd), .carry(min_carry)
   );
   bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
      .clk(clk), .rst(rst), .clr(clear), .inc(set_en ? inc_hour : min_carry),
      .value(hour_bcd), .carry(hour_carry)
   );
   // day wrap pulse aligned with the 00:00:00 display; hour wraps from setting do not count
   always_ff @(posedge clk)
      day_wrap <= ~rst & ~set_en & hour_carry;
`ifdef ALARM_EN
   logic rolled;
   // flag a counted seconds rollover so the compare sees the updated hour/minute
   always_ff @(posedge clk)
      rolled <= ~rst & sec_carry;
   assign alarm = rolled & (hour_bcd == alarm_hour) & (min_bcd == alarm_min);
`else
   assign alarm = 1'b0 & ^{alarm_hour, alarm_min};
`endif
endmodule

// File: tb/tb_tick_time_counter.sv
// tb_tick_time_counter: vector table, corner sequences and random stimulus against a seconds-of-day model
module tb_tick_time_counter;
   logic clk = 1'b0;
   logic rst, tick, run, clear, set_en, inc_hour, inc_min;
   logic [7:0] alarm_hour, alarm_min;
   logic [7:0] s1, m1, h1, s4, m4, h4;
   logic r1, r4, dw1, dw4, al1, al4;
   int n_chk = 0, n_pass = 0;
`ifdef ALARM_EN
   localparam logic AL_EXP = 1'b1;
`else
   localparam logic AL_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   tick_time_counter #(.TICK_DIV(1), .START_RUNNING(1'b0)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .set_en(set_en),
      .inc_hour(inc_hour), .inc_min(inc_min), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .sec_bcd(s1), .min_bcd(m1), .hour_bcd(h1), .running(r1), .day_wrap(dw1), .alarm(al1)
   );
   tick_time_counter #(.TICK_DIV(4), .START_RUNNING(1'b0)) dut4 (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .set_en(set_en),
      .inc_hour(inc_hour), .inc_min(inc_min), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
      .sec_bcd(s4), .min_bcd(m4), .hour_bcd(h4), .running(r4), .day_wrap(dw4), .alarm(al4)
   );

   typedef struct {int h; int m; int s; int div; int st; int dw; int al;} mdl_t;
   mdl_t md1, md4;

   typedef struct {logic [5:0] in; logic [23:0] smh; logic rn;} vec_t;
   vec_t tv[12];

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   // st: 0 stopped, 1 running, 2 setting; time kept as seconds of day
   function automatic mdl_t step(input mdl_t x, input int td);
      int t;
      x.dw = 0;
      x.al = 0;
      if (rst) begin
         x = '{default: 0};
         return x;
      end
      if (clear) begin
         x.h = 0; x.m = 0; x.s = 0; x.div = 0;
      end else if (set_en) begin
         x.s = 0; x.div = 0;
         if (inc_hour) x.h = (x.h + 1) % 24;
         if (inc_min) x.m = (x.m + 1) % 60;
      end else if (x.st == 1 && tick) begin
         if (x.div == td - 1) begin
            x.div = 0;
            t = x.h * 3600 + x.m * 60 + x.s + 1;
            if (t == 86400) begin
               t = 0;
               x.dw = 1;
            end
            x.h = t / 3600; x.m = (t / 60) % 60; x.s = t % 60;
`ifdef ALARM_EN
            if (x.s == 0 && bcd(x.h) == alarm_hour && bcd(x.m) == alarm_min) x.al = 1;
`endif
         end else x.div = x.div + 1;
      end
      x.st = set_en ? 2 : run ? 1 : 0;
      return x;
   endfunction

   function automatic logic [26:0] exp_of(input mdl_t x);
      return {bcd(x.s), bcd(x.m), bcd(x.h), x.st == 1, x.dw[0], x.al[0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drv(input logic c, input logic se, input logic r, input logic t, input logic ih, input logic im);
      clear = c; set_en = se; run = r; tick = t; inc_hour = ih; inc_min = im;
   endtask

   task automatic cyc();
      @(posedge clk);
      md1 = step(md1, 1);
      md4 = step(md4, 4);
      @(negedge clk);
      chk("model1", {s1, m1, h1, r1, dw1, al1}, exp_of(md1));
      chk("model4", {s4, m4, h4, r4, dw4, al4}, exp_of(md4));
   endtask

   initial begin
      md1 = '{default: 0};
      md4 = '{default: 0};
      alarm_hour = 8'h00;
      alarm_min = 8'h00;
      rst = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cyc();
      cyc();
      chk("reset", {s1, m1, h1, r1, dw1, al1}, 32'h0);
      rst = 1'b0;

      tv[0]  = '{6'b001000, 24'h000000, 1'b1};
      tv[1]  = '{6'b001100, 24'h010000, 1'b1};
      tv[2]  = '{6'b001100, 24'h020000, 1'b1};
      tv[3]  = '{6'b000100, 24'h030000, 1'b0};
      tv[4]  = '{6'b000100, 24'h030000, 1'b0};
      tv[5]  = '{6'b010011, 24'h000101, 1'b0};
      tv[6]  = '{6'b010101, 24'h000201, 1'b0};
      tv[7]  = '{6'b001100, 24'h000201, 1'b1};
      tv[8]  = '{6'b001100, 24'h010201, 1'b1};
      tv[9]  = '{6'b101100, 24'h000000, 1'b1};
      tv[10] = '{6'b001110, 24'h010000, 1'b1};
      tv[11] = '{6'b001001, 24'h010000, 1'b1};
      for (int i = 0; i < 12; i++) begin
         drv(tv[i].in[5], tv[i].in[4], tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
         cyc();
         chk($sformatf("vec%0d", i), {s1, m1, h1, r1}, {tv[i].smh, tv[i].rn});
      end

      drv(1, 0, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 60; i++) begin
         drv(0, 0, 1, 1, 0, 0);
         cyc();
         if (i == 8) chk("tick9", s1, 32'h09);
         if (i == 9) chk("tick10", s1, 32'h10);
      end
      chk("sixty_ticks", {m1, s1}, 32'h0100);

      drv(1, 0, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 1, 1, 0, 0);
         cyc();
         chk($sformatf("div4_t%0d", i), s4, (i == 3) ? 32'h01 : 32'h00);
      end

      drv(1, 1, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 34; i++) begin
         drv(0, 1, 1, 1, i < 12, 1);
         cyc();
      end
      drv(0, 0, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 56; i++) begin
         drv(0, 0, 1, 1, 0, 0);
         cyc();
      end
      chk("preload_123456", {h1, m1, s1}, 32'h123456);
      drv(1, 0, 1, 1, 0, 0);
      cyc();
      chk("clear_tick", {h1, m1, s1, r1, dw1}, 32'h2);

      drv(1, 1, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 59; i++) begin
         drv(0, 1, 1, 0, i < 23, 1);
         cyc();
      end
      drv(0, 0, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 58; i++) begin
         drv(0, 0, 1, 1, 0, 0);
         cyc();
      end
      chk("preload_235958", {h1, m1, s1}, 32'h235958);
      cyc();
      chk("at_235959", {h1, m1, s1, dw1}, {7'h0, 24'h235959, 1'b0});
      cyc();
      chk("day_wrap_on", {h1, m1, s1, dw1}, 32'h1);
      drv(0, 0, 1, 0, 0, 0);
      cyc();
      chk("day_wrap_off", dw1, 32'h0);

      drv(1, 1, 0, 1, 0, 0);
      cyc();
      for (int i = 0; i < 61; i++) begin
         drv(0, 1, 0, 1, i < 25, 1);
         cyc();
      end
      chk("set_wrap", {h1, m1, s1}, 32'h010100);

      alarm_hour = 8'h07;
      alarm_min = 8'h30;
      drv(1, 1, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 29; i++) begin
         drv(0, 1, 1, 0, i < 7, 1);
         cyc();
      end
      drv(0, 0, 1, 0, 0, 0);
      cyc();
      for (int i = 0; i < 59; i++) begin
         drv(0, 0, 1, 1, 0, 0);
         cyc();
      end
      chk("pre_alarm", {h1, m1, s1, al1}, {7'h0, 24'h072959, 1'b0});
      cyc();
      chk("alarm_on", {h1, m1, s1, al1}, {7'h0, 24'h073000, AL_EXP});
      drv(0, 0, 1, 0, 0, 0);
      cyc();
      chk("alarm_off", al1, 32'h0);

      drv(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 31) == 0) set_en = ~set_en;
         if ($urandom_range(0, 15) == 0) run = ~run;
         clear = $urandom_range(0, 63) == 0;
         tick = 1'($urandom_range(0, 1));
         inc_hour = $urandom_range(0, 3) == 0;
         inc_min = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 199) == 0) begin
            alarm_hour = bcd(md1.h);
            alarm_min = bcd((md1.m + 1) % 60);
         end
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
